// File: rtl/mdu_pkg.sv
// mdu_pkg: shared definitions for the multiply/divide unit.
//   mdu_op_t      : operation codes carried on the 4-bit opt field
//   mdu_state_t   : FSM states (IDLE / RUN)
//   MUL_CYCLES_DEF, DIV_CYCLES_DEF : default busy latencies
//   CNT_W         : width of the latency down-counter
// Optional feature macro: MDU_MADD_EN (enables madd/maddu, opt 7/8).
package mdu_pkg;

  typedef enum logic [3:0] {
    OP_NONE  = 4'd0,
    OP_MULT  = 4'd1,
    OP_MULTU = 4'd2,
    OP_DIV   = 4'd3,
    OP_DIVU  = 4'd4,
    OP_MTHI  = 4'd5,
    OP_MTLO  = 4'd6,
    OP_MADD  = 4'd7,
    OP_MADDU = 4'd8
  } mdu_op_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } mdu_state_t;

  localparam int MUL_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF = 10;
  localparam int CNT_W          = 16;

endpackage

// File: rtl/mdu_if.sv
// mdu_if: EX-stage operand/handshake bundle between the pipeline and the MDU.
//   v1, v2 : forwarded operands (rs, rt)
//   opt    : raw 4-bit operation code (may carry invalid codes)
//   start  : EX holds a valid MDU instruction this cycle
//   req    : exception/interrupt flush, suppresses any start
//   busy   : operation in flight
//   hi, lo : architectural HI/LO registers
// Modports: master (pipeline side), slave (MDU side).
interface mdu_if;
  logic [31:0] v1;
  logic [31:0] v2;
  logic [3:0]  opt;
  logic        start;
  logic        req;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (output v1, v2, opt, start, req, input busy, hi, lo);
  modport slave  (input v1, v2, opt, start, req, output busy, hi, lo);
endinterface

// File: rtl/mdu_core.sv
// mdu_core: purely combinational datapath of the MDU.
//   v1_i, v2_i : operands
//   opt_i      : operation code
//   hi_i, lo_i : current HI/LO (accumulate source and pass-through value)
//   nhi_o, nlo_o : result pair to be committed later
//   divZero_o  : div/divu with a zero divisor
// Macro MDU_MADD_EN adds the madd/maddu accumulate path.
module mdu_core
  import mdu_pkg::*;
(
  input  logic [31:0] v1_i,
  input  logic [31:0] v2_i,
  input  logic [3:0]  opt_i,
  input  logic [31:0] hi_i,
  input  logic [31:0] lo_i,
  output logic [31:0] nhi_o,
  output logic [31:0] nlo_o,
  output logic        divZero_o
);

  logic [63:0] prodS;
  logic [63:0] prodU;
  logic [31:0] divisor;
  logic [31:0] absA;
  logic [31:0] absB;
  logic [31:0] qMag;
  logic [31:0] rMag;
  logic [31:0] qU;
  logic [31:0] rU;

  // Low 64 bits of a 64x64 product of sign-extended operands equal the
  // exact signed 32x32 product.
  assign prodS = {{32{v1_i[31]}}, v1_i} * {{32{v2_i[31]}}, v2_i};
  assign prodU = {32'd0, v1_i} * {32'd0, v2_i};

  // Divisor forced to 1 on zero so the divider never sees x/0; the
  // result is discarded anyway through divZero_o.
  assign divisor = (v2_i == 32'd0) ? 32'd1 : v2_i;

  // Signed divide on magnitudes; 0x80000000 has magnitude 0x80000000 as an
  // unsigned value, which makes the INT_MIN / -1 case fall out naturally.
  assign absA = v1_i[31]    ? (32'd0 - v1_i)    : v1_i;
  assign absB = divisor[31] ? (32'd0 - divisor) : divisor;
  assign qMag = absA / absB;
  assign rMag = absA % absB;
  assign qU   = v1_i / divisor;
  assign rU   = v1_i % divisor;

`ifdef MDU_MADD_EN
  logic [63:0] acc;
  assign acc = {hi_i, lo_i};
`endif

  always_comb begin
    nhi_o     = hi_i;
    nlo_o     = lo_i;
    divZero_o = 1'b0;
    case (opt_i)
      OP_MULT:  {nhi_o, nlo_o} = prodS;
      OP_MULTU: {nhi_o, nlo_o} = prodU;
      OP_DIV: begin
        if (v2_i == 32'd0) begin
          divZero_o = 1'b1;
        end else begin
          nlo_o = (v1_i[31] ^ v2_i[31]) ? (32'd0 - qMag) : qMag;
          nhi_o = v1_i[31] ? (32'd0 - rMag) : rMag;
        end
      end
      OP_DIVU: begin
        if (v2_i == 32'd0) begin
          divZero_o = 1'b1;
        end else begin
          nlo_o = qU;
          nhi_o = rU;
        end
      end
`ifdef MDU_MADD_EN
      OP_MADD:  {nhi_o, nlo_o} = acc + prodS;
      OP_MADDU: {nhi_o, nlo_o} = acc + prodU;
`endif
      default: ;
    endcase
  end

endmodule

// File: rtl/mdu.sv
// mdu: multi-cycle multiply/divide unit owning HI/LO.
//   clk   : system clock
//   reset : asynchronous active-high reset
//   bus   : mdu_if.slave (v1, v2, opt, start, req in; busy, hi, lo out)
// Parameters MUL_CYCLES / DIV_CYCLES set busy latencies.
// Macro MDU_MADD_EN enables madd/maddu (opt 7/8); otherwise they decode as none.
module mdu
  import mdu_pkg::*;
#(
  parameter int MUL_CYCLES = MUL_CYCLES_DEF,
  parameter int DIV_CYCLES = DIV_CYCLES_DEF
) (
  input logic   clk,
  input logic   reset,
  mdu_if.slave  bus
);

  mdu_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      nhi_q, nhi_d;
  logic [31:0]      nlo_q, nlo_d;
  logic             divZero_q, divZero_d;
  logic [31:0]      hi_q, hi_d;
  logic [31:0]      lo_q, lo_d;

  logic [31:0] coreHi;
  logic [31:0] coreLo;
  logic        coreDivZero;
  logic        opValid;
  logic        isLong;
  logic        isDiv;
  logic        accept;

  mdu_core u_core (
    .v1_i      (bus.v1),
    .v2_i      (bus.v2),
    .opt_i     (bus.opt),
    .hi_i      (hi_q),
    .lo_i      (lo_q),
    .nhi_o     (coreHi),
    .nlo_o     (coreLo),
    .divZero_o (coreDivZero)
  );

  // Decode the raw opcode; anything not listed behaves as none.
  always_comb begin
    opValid = 1'b0;
    isLong  = 1'b0;
    isDiv   = 1'b0;
    case (bus.opt)
      OP_MULT, OP_MULTU: begin
        opValid = 1'b1;
        isLong  = 1'b1;
      end
      OP_DIV, OP_DIVU: begin
        opValid = 1'b1;
        isLong  = 1'b1;
        isDiv   = 1'b1;
      end
      OP_MTHI, OP_MTLO: opValid = 1'b1;
`ifdef MDU_MADD_EN
      OP_MADD, OP_MADDU: begin
        opValid = 1'b1;
        isLong  = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  assign accept = bus.start && !bus.req && (state_q == ST_IDLE) && opValid;

  // Next-state logic: results are computed into the shadow pair at accept and
  // only copied to HI/LO when the counter expires, so a flush arriving during
  // RUN cannot disturb an operation that has already started.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    nhi_d     = nhi_q;
    nlo_d     = nlo_q;
    divZero_d = divZero_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (bus.opt == OP_MTHI) begin
            hi_d = bus.v1;
          end else if (bus.opt == OP_MTLO) begin
            lo_d = bus.v1;
          end else if (isLong) begin
            nhi_d     = coreHi;
            nlo_d     = coreLo;
            divZero_d = coreDivZero;
            cnt_d     = isDiv ? CNT_W'(DIV_CYCLES) : CNT_W'(MUL_CYCLES);
            state_d   = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        if (cnt_q == CNT_W'(1)) begin
          if (!divZero_q) begin
            hi_d = nhi_q;
            lo_d = nlo_q;
          end
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers; reset discards any in-flight shadow result.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      nhi_q     <= '0;
      nlo_q     <= '0;
      divZero_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      nhi_q     <= nhi_d;
      nlo_q     <= nlo_d;
      divZero_q <= divZero_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  assign bus.busy = (state_q == ST_RUN);
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule

// File: tb/tb_mdu.sv
// tb_mdu: scoreboard bench for mdu. The driver issues one instruction at a
// time, predicts HI/LO and busy length from an arithmetic reference model and
// queues the prediction; a monitor counts busy cycles and, once the unit is
// idle again, pops and compares. Honours MDU_MADD_EN like the design.
module tb_mdu;
  import mdu_pkg::*;

  typedef struct {
    int          len;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [3:0]  op;
  } expect_t;

  logic clk;
  logic reset;
  mdu_if bus ();

  mdu dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  expect_t     expQ[$];
  int          vectors     = 0;
  int          miscompares = 0;
  int          reqCnt      = 0;
  int          doneCnt     = 0;
  int          runCnt      = 0;
  logic [31:0] hiM         = 32'd0;
  logic [31:0] loM         = 32'd0;

  task automatic checkOutput(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // Reference model: what the instruction does to HI/LO and how long busy lasts.
  task automatic modelOp(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic rq, output int len);
    longint      q;
    longint      r;
    logic [63:0] p;
    len = 0;
    if (rq) return;
    case (op)
      4'd1: begin p = longint'($signed(a)) * longint'($signed(b)); {hiM, loM} = p; len = 5; end
      4'd2: begin p = {32'd0, a} * {32'd0, b}; {hiM, loM} = p; len = 5; end
      4'd3: begin
        len = 10;
        if (b != 0) begin
          q = longint'($signed(a)) / longint'($signed(b));
          r = longint'($signed(a)) % longint'($signed(b));
          loM = q[31:0];
          hiM = r[31:0];
        end
      end
      4'd4: begin
        len = 10;
        if (b != 0) begin
          loM = a / b;
          hiM = a % b;
        end
      end
      4'd5: hiM = a;
      4'd6: loM = a;
`ifdef MDU_MADD_EN
      4'd7: begin p = {hiM, loM} + 64'(longint'($signed(a)) * longint'($signed(b))); {hiM, loM} = p; len = 5; end
      4'd8: begin p = {hiM, loM} + ({32'd0, a} * {32'd0, b}); {hiM, loM} = p; len = 5; end
`endif
      default: ;
    endcase
  endtask

  // Issue one instruction (called at a falling edge) and wait for completion.
  // midReq raises req plus a stray start during the third busy cycle.
  task automatic applyStimulus(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                               input logic rq, input bit midReq);
    int      len;
    int      i;
    expect_t e;
    bus.v1    = a;
    bus.v2    = b;
    bus.opt   = op;
    bus.start = 1'b1;
    bus.req   = rq;
    modelOp(op, a, b, rq, len);
    e.len = len;
    e.hi  = hiM;
    e.lo  = loM;
    e.op  = op;
    expQ.push_back(e);
    @(negedge clk);
    bus.start = 1'b0;
    bus.req   = 1'b0;
    bus.opt   = 4'd0;
    i = 0;
    while (bus.busy && i < 60) begin
      if (midReq && i == 2) begin
        bus.req   = 1'b1;
        bus.start = 1'b1;
        bus.opt   = 4'd4;
        bus.v2    = 32'd3;
      end else begin
        bus.req   = 1'b0;
        bus.start = 1'b0;
        bus.opt   = 4'd0;
      end
      @(negedge clk);
      i++;
    end
    bus.req   = 1'b0;
    bus.start = 1'b0;
    bus.opt   = 4'd0;
    if (bus.busy) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL busy_timeout: busy still %b after %0d cycles, expected 0", bus.busy, i);
    end
    reqCnt++;
    for (int k = 0; k < 5 && doneCnt != reqCnt; k++) @(negedge clk);
    if (doneCnt != reqCnt) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL monitor_timeout: done %0d, expected %0d", doneCnt, reqCnt);
    end
  endtask

  // Monitor: counts busy cycles and checks each completed instruction.
  initial begin
    expect_t e;
    forever begin
      @(negedge clk);
      if (reset) begin
        runCnt = 0;
      end else if (bus.busy) begin
        runCnt++;
      end else if (reqCnt != doneCnt) begin
        if (expQ.size() == 0) begin
          vectors++;
          miscompares++;
          $display("[TB] FAIL queue_empty: got %0d entries, expected at least 1", expQ.size());
        end else begin
          e = expQ.pop_front();
          checkOutput($sformatf("busy_len op%0d", e.op), 32'(runCnt), 32'(e.len));
          checkOutput($sformatf("hi op%0d", e.op), bus.hi, e.hi);
          checkOutput($sformatf("lo op%0d", e.op), bus.lo, e.lo);
        end
        runCnt = 0;
        doneCnt++;
      end
    end
  end

  function automatic logic [31:0] randOperand();
    logic [31:0] v;
    case ($urandom_range(0, 7))
      0: v = 32'h0000_0000;
      1: v = 32'h0000_0001;
      2: v = 32'hFFFF_FFFF;
      3: v = 32'h8000_0000;
      4: v = 32'($urandom_range(0, 20));
      default: v = $urandom;
    endcase
    return v;
  endfunction

  initial begin
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        rq;
    bus.v1 = '0; bus.v2 = '0; bus.opt = '0; bus.start = 1'b0; bus.req = 1'b0;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("reset_busy", {31'd0, bus.busy}, 32'd0);
    checkOutput("reset_hi", bus.hi, 32'd0);
    checkOutput("reset_lo", bus.lo, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    $display("[TB] directed sequence");
    applyStimulus(4'd1, 32'hFFFF_FFFE, 32'd3, 1'b0, 1'b0);
    applyStimulus(4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
    applyStimulus(4'd3, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0);
    applyStimulus(4'd5, 32'h1234_5678, 32'd0, 1'b0, 1'b0);
    applyStimulus(4'd6, 32'h0000_0000, 32'd0, 1'b0, 1'b0);
    applyStimulus(4'd3, 32'd5, 32'd0, 1'b0, 1'b0);
    applyStimulus(4'd3, 32'd100, 32'd7, 1'b1, 1'b0);
    applyStimulus(4'd3, 32'd100, 32'd7, 1'b0, 1'b1);
    applyStimulus(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
    applyStimulus(4'd0, 32'hDEAD_BEEF, 32'd1, 1'b0, 1'b0);
    applyStimulus(4'd12, 32'hDEAD_BEEF, 32'd1, 1'b0, 1'b0);
    applyStimulus(4'd5, 32'h0000_0000, 32'd0, 1'b0, 1'b0);
    applyStimulus(4'd6, 32'hFFFF_FFFF, 32'd0, 1'b0, 1'b0);
    applyStimulus(4'd8, 32'd1, 32'd1, 1'b0, 1'b0);

    // Reset in the fourth busy cycle of a mult, then an immediate new start.
    bus.v1 = 32'd7; bus.v2 = 32'd9; bus.opt = 4'd1; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0; bus.opt = 4'd0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    #1;
    checkOutput("midrun_reset_busy", {31'd0, bus.busy}, 32'd0);
    checkOutput("midrun_reset_hi", bus.hi, 32'd0);
    checkOutput("midrun_reset_lo", bus.lo, 32'd0);
    hiM = 32'd0;
    loM = 32'd0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    applyStimulus(4'd2, 32'd6, 32'd7, 1'b0, 1'b0);

    $display("[TB] random sequence");
    for (int n = 0; n < 80; n++) begin
      op = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(1, 8));
      a  = randOperand();
      b  = randOperand();
      rq = ($urandom_range(0, 7) == 0);
      applyStimulus(op, a, b, rq, ($urandom_range(0, 5) == 0));
    end

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mdu.md
# mdu

Multi-cycle multiply/divide unit for the P7 pipeline's EX stage, beside the single-cycle ALU. Takes the same forwarded operand pair and a 4-bit operation code, runs MIPS mult/multu/div/divu with fixed latencies, and owns the architectural HI/LO registers. Exposes a start/busy handshake so the hazard unit can stall mfhi/mflo and later MDU instructions until results commit.

## Interface
- MUL_CYCLES, default 5: busy cycles for mult/multu/madd/maddu.
- DIV_CYCLES, default 10: busy cycles for div/divu.
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high; one clock; clears all state.
- v1  in  32  operand A (rs), forwarded value.
- v2  in  32  operand B (rt), forwarded value.
- opt  in  4  operation: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 madd, 8 maddu. Other codes are none.
- start  in  1  EX holds a valid MDU instruction this cycle.
- req  in  1  exception/interrupt flush this cycle; suppresses any start.
- busy  out  1  operation in flight; reset 0.
- hi  out  32  HI register; reset 0.
- lo  out  32  LO register; reset 0.

## Operation
- States: IDLE, RUN. Internal down-counter cnt and shadow result pair {nhi, nlo}.
- Accepted start: start=1, req=0, state IDLE, opt is a valid code.
- mult/multu/div/divu/madd/maddu accepted: compute result into {nhi, nlo} at that edge, load cnt with MUL_CYCLES or DIV_CYCLES, go to RUN.
- RUN: cnt decrements each cycle. At the edge where cnt reaches 1, write {nhi, nlo} to {hi, lo} and return to IDLE.
- mthi/mtlo accepted: hi<=v1 or lo<=v1 at that edge. No busy, no RUN.
- mult: {hi,lo} = signed 64-bit v1*v2. multu: same, unsigned.
- madd/maddu: {hi,lo} + signed/unsigned 64-bit product, modulo 2^64. The {hi,lo} value used is the one at the accept edge.
- div: lo = quotient truncated toward zero, hi = remainder with the sign of v1. divu: unsigned.
- 0x80000000 div 0xFFFFFFFF: lo=0x80000000, hi=0. No trap.
- Divide by zero (v2=0, div or divu): full DIV_CYCLES busy; hi/lo left unchanged at commit.
- start while busy: ignored. The hazard unit stalls, so this is a protocol violation and has no effect.
- req=1 with start=1: nothing accepted, no state change.
- req=1 during RUN: the operation continues and commits normally. Flushing applies only to instructions that have not yet started.
- opt=0 or an invalid code with start=1: no effect.

## Timing
- Accept at edge T: busy=1 from T+1 through T+MUL_CYCLES (or T+DIV_CYCLES).
- New hi/lo are visible, and busy=0, starting at T+MUL_CYCLES+1 (or T+DIV_CYCLES+1).
- A new start is accepted in the first cycle busy=0.
- The hazard unit stalls on busy=1, and also in the accept cycle itself (start=1 with an MDU opt).
- mthi/mtlo: hi/lo updated at the accept edge and visible the next cycle.
- reset asserted mid-RUN: immediately IDLE, busy=0, hi=lo=0, cnt=0, and the shadow result is discarded.
- hi/lo change only at commit, mthi/mtlo, or reset.

## Configuration
- MDU_MADD_EN defined: opt 7/8 (madd/maddu) implemented as above.
- MDU_MADD_EN undefined: opt 7/8 decode as none. The accumulate path and its 64-bit adder are removed.

## Structure
- Shared package mdu_pkg holds:
  - enum mdu_op_t with the opt encodings.
  - the state enum.
  - MUL_CYCLES/DIV_CYCLES defaults.
- The decoder imports mdu_op_t so both sides share one encoding.
- One sub-module, mdu_core: purely combinational, takes v1, v2, opt, hi, lo and returns {nhi, nlo} plus a div-by-zero flag.
- The top module holds the FSM, counter and registers.

## Test plan
- mult 0xFFFFFFFE (−2) × 3 -> busy for 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFA, busy=0.
- multu 0xFFFFFFFF × 0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001 after 5 cycles. div −7 / 2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF after 10 cycles.
- mthi 0x12345678, then div 5 / 0 -> busy for 10 cycles; hi stays 0x12345678, lo stays 0.
- start div with req=1 -> busy stays 0, hi/lo unchanged. div accepted, then req=1 at busy cycle 3 -> still commits at cycle 10.
- reset pulse at busy cycle 4 of a mult -> busy=0, hi=lo=0 immediately. A start in the cycle after reset releases is accepted.
- With MDU_MADD_EN: hi:lo=0:0xFFFFFFFF, then maddu 1 × 1 -> hi=1, lo=0. Without MDU_MADD_EN: same stimulus -> busy stays 0, hi/lo unchanged.
